// File: rtl/mem_access_stage_pkg.sv
// ============================================================================
// Module : mem_access_stage_pkg
// Brief  : Opcode constants and FSM state type for the MEM pipeline stage.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mem_access_stage_pkg;

  localparam int unsigned OPCODE_W = 6;
  localparam logic [OPCODE_W-1:0] OP_LW = 6'h23;
  localparam logic [OPCODE_W-1:0] OP_SW = 6'h2B;
  localparam int unsigned NOP = 0;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_access_stage.sv
// ============================================================================
// Module : mem_access_stage
// Brief  : MEM stage; runs LW/SW over a req/ack port, passes other ops through.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] IR_in,
  input  logic [WIDTH-3:0] PC_in,
  input  logic [WIDTH-1:0] Z_in,
  input  logic [WIDTH-1:0] B_in,
  output logic             stall_out,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [WIDTH-1:0] dmem_addr,
  output logic [WIDTH-1:0] dmem_wdata,
  input  logic [WIDTH-1:0] dmem_rdata,
  input  logic             dmem_ack,
  output logic             valid_out,
  output logic [WIDTH-1:0] IR_out,
  output logic [WIDTH-3:0] PC_out,
  output logic [WIDTH-1:0] Z_out,
  output logic             err_out
);

  localparam bit         c_timeout_en   = (TIMEOUT != 0);
  localparam logic [7:0] c_timeout_last = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_timer;
  logic [WIDTH-1:0] r_ir;
  logic [WIDTH-3:0] r_pc;
  logic             r_is_ld;

  logic [OPCODE_W-1:0] w_op;
  logic                w_is_ld;
  logic                w_is_st;
  logic                w_start;
  logic                w_pass;
  logic                w_done;
  logic                w_abort;

  assign w_op      = IR_in[WIDTH-1 -: OPCODE_W];
  assign w_is_ld   = (w_op == OP_LW);
  assign w_is_st   = (w_op == OP_SW);
  assign stall_out = (r_state == ST_WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_pass      = 1'b0;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (valid_in && (w_is_ld || w_is_st)) begin
          w_start     = 1'b1;
          w_state_nxt = ST_WAIT;
        end else if (valid_in) begin
          w_pass = 1'b1;
        end
      end
      ST_WAIT: begin
        // Ack takes priority over a timeout landing on the same cycle.
        if (dmem_ack) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (c_timeout_en && (r_timer == c_timeout_last)) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer    <= 8'd0;
      r_ir       <= '0;
      r_pc       <= '0;
      r_is_ld    <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      valid_out  <= 1'b0;
      IR_out     <= '0;
      PC_out     <= '0;
      Z_out      <= '0;
      err_out    <= 1'b0;
    end else begin
      err_out   <= w_abort;
      valid_out <= 1'b0;
      IR_out    <= WIDTH'(NOP);

      if (w_start) begin
        r_ir       <= IR_in;
        r_pc       <= PC_in;
        r_is_ld    <= w_is_ld;
        dmem_req   <= 1'b1;
        dmem_we    <= w_is_st;
        dmem_addr  <= Z_in;
        dmem_wdata <= B_in;
        r_timer    <= 8'd0;
      end else if (r_state == ST_WAIT && r_timer != 8'hFF) begin
        r_timer <= r_timer + 8'd1;
      end

      if (w_pass) begin
        valid_out <= 1'b1;
        IR_out    <= IR_in;
        PC_out    <= PC_in;
        Z_out     <= Z_in;
      end

      // dmem_addr doubles as the captured effective address for SW results.
      if (w_done) begin
        dmem_req  <= 1'b0;
        valid_out <= 1'b1;
        IR_out    <= r_ir;
        PC_out    <= r_pc;
        Z_out     <= r_is_ld ? dmem_rdata : dmem_addr;
      end

      if (w_abort) dmem_req <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_stage.sv
// ============================================================================
// Module : tb_mem_access_stage
// Brief  : Randomized self-checking bench for mem_access_stage.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  localparam int W     = 32;
  localparam int TMO   = 16;
  localparam int NEVER = 255;

  typedef struct {
    logic         v;
    logic [W-1:0] ir;
    logic [W-3:0] pc;
    logic [W-1:0] z;
    logic [W-1:0] b;
    int           ack_dly;
    logic [W-1:0] rdata;
  } instr_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         valid_in;
  logic [W-1:0] IR_in, Z_in, B_in;
  logic [W-3:0] PC_in;
  logic         stall_out, dmem_req, dmem_we, dmem_ack, valid_out, err_out;
  logic [W-1:0] dmem_addr, dmem_wdata, dmem_rdata, IR_out, Z_out;
  logic [W-3:0] PC_out;

  mem_access_stage #(.WIDTH(W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .IR_in(IR_in), .PC_in(PC_in),
    .Z_in(Z_in), .B_in(B_in), .stall_out(stall_out), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .valid_out(valid_out),
    .IR_out(IR_out), .PC_out(PC_out), .Z_out(Z_out), .err_out(err_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the outstanding memory op and the expected registered outputs.
  bit           m_pend;
  instr_t       m_op;
  int           m_waited;
  logic         exp_valid, exp_err;
  logic [W-1:0] exp_ir, exp_z;
  logic [W-3:0] exp_pc;

  instr_t up_cur;
  bit     up_hold;
  instr_t dir_q[$];

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic bit is_mem(input logic [W-1:0] ir);
    return (ir[W-1:W-6] == OP_LW) || (ir[W-1:W-6] == OP_SW);
  endfunction

  function automatic instr_t make(input logic [5:0] op, input logic [W-1:0] z,
                                  input logic [W-1:0] b, input int ack_dly,
                                  input logic [W-1:0] rdata);
    instr_t t;
    t.v = 1'b1; t.ir = {op, 26'($urandom)}; t.pc = 30'($urandom);
    t.z = z; t.b = b; t.ack_dly = ack_dly; t.rdata = rdata;
    return t;
  endfunction

  function automatic instr_t rand_instr();
    instr_t      t;
    logic [5:0]  op;
    int unsigned sel = $urandom_range(0, 3);
    if (sel == 0)      op = OP_LW;
    else if (sel == 1) op = OP_SW;
    else begin
      op = 6'($urandom);
      while (op == OP_LW || op == OP_SW) op = 6'($urandom);
    end
    t = make(op, $urandom, $urandom,
             ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, 18)), $urandom);
    t.v = ($urandom_range(0, 4) != 0);
    return t;
  endfunction

  task automatic model_reset();
    m_pend = 0; m_waited = 0; up_hold = 0;
    exp_valid = 0; exp_err = 0; exp_ir = '0; exp_pc = '0; exp_z = '0;
  endtask

  task automatic check_outputs();
    check_value("stall_out", stall_out, m_pend);
    check_value("dmem_req", dmem_req, m_pend);
    if (m_pend) begin
      check_value("dmem_we", dmem_we, m_op.ir[W-1:W-6] == OP_SW);
      check_value("dmem_addr", dmem_addr, m_op.z);
      check_value("dmem_wdata", dmem_wdata, m_op.b);
    end
    check_value("valid_out", valid_out, exp_valid);
    check_value("IR_out", IR_out, exp_ir);
    check_value("err_out", err_out, exp_err);
    if (exp_valid) begin
      check_value("PC_out", PC_out, exp_pc);
      check_value("Z_out", Z_out, exp_z);
    end
  endtask

  // Called at a falling edge: present upstream/memory inputs and advance the model.
  task automatic step();
    if (!up_hold) up_cur = (dir_q.size() != 0) ? dir_q.pop_front() : rand_instr();
    up_hold = m_pend;
    valid_in = up_cur.v; IR_in = up_cur.ir; PC_in = up_cur.pc; Z_in = up_cur.z; B_in = up_cur.b;
    if (m_pend) begin
      dmem_ack   = (m_waited == m_op.ack_dly);
      dmem_rdata = m_op.rdata;
    end else begin
      dmem_ack   = ($urandom_range(0, 7) == 0);
      dmem_rdata = $urandom;
    end
    exp_err = 0;
    if (!m_pend) begin
      exp_valid = 0; exp_ir = '0;
      if (up_cur.v && is_mem(up_cur.ir)) begin
        m_pend = 1; m_op = up_cur; m_waited = 0;
      end else if (up_cur.v) begin
        exp_valid = 1; exp_ir = up_cur.ir; exp_pc = up_cur.pc; exp_z = up_cur.z;
      end
    end else begin
      exp_valid = 0; exp_ir = '0;
      if (dmem_ack) begin
        m_pend = 0; exp_valid = 1; exp_ir = m_op.ir; exp_pc = m_op.pc;
        exp_z = (m_op.ir[W-1:W-6] == OP_LW) ? m_op.rdata : m_op.z;
      end else if (TMO != 0 && m_waited + 1 == TMO) begin
        m_pend = 0; exp_err = 1;
      end else begin
        m_waited++;
      end
    end
  endtask

  task automatic run_cycle();
    @(negedge clk);
    check_outputs();
    step();
  endtask

  initial begin
    instr_t lw;
    bit     reached;
    rst_n = 1'b0; valid_in = 0; IR_in = '0; PC_in = '0; Z_in = '0; B_in = '0;
    dmem_ack = 0; dmem_rdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    dir_q.push_back(make(6'h00, 32'd5, 32'd0, NEVER, '0));
    dir_q.push_back(make(OP_LW, 32'h100, 32'd0, 3, 32'hDEADBEEF));
    dir_q.push_back(make(OP_SW, 32'h40, 32'h1234, 1, '0));
    dir_q.push_back(make(OP_LW, 32'h80, 32'd0, 2, 32'hCAFEF00D));
    dir_q.push_back(make(6'h01, 32'h77, 32'd0, NEVER, '0));
    dir_q.push_back(make(OP_LW, 32'h200, 32'd0, NEVER, '0));
    dir_q.push_back(make(6'h02, 32'h99, 32'd0, NEVER, '0));
    for (int i = 0; i < 200 && (dir_q.size() != 0 || m_pend || up_hold); i++) run_cycle();

    for (int i = 0; i < 3000; i++) run_cycle();

    // Asynchronous reset in the middle of an outstanding load.
    lw = make(OP_LW, 32'h300, 32'd0, NEVER, '0);
    dir_q.push_back(lw);
    reached = 0;
    for (int i = 0; i < 200 && !reached; i++) begin
      run_cycle();
      reached = m_pend && (m_op.ir == lw.ir) && (m_waited >= 3);
    end
    check_value("reset_setup_reached", reached, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_value("async_rst_req", dmem_req, 1'b0);
    check_value("async_rst_stall", stall_out, 1'b0);
    check_value("async_rst_valid", valid_out, 1'b0);
    @(negedge clk);
    valid_in = 0; dmem_ack = 0;
    model_reset();
    dir_q.delete();
    rst_n = 1'b1;
    dir_q.push_back(make(6'h00, 32'h55, 32'd0, NEVER, '0));
    for (int i = 0; i < 20; i++) run_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
